gpu_cmd_queue: RTL and testbench
================================

# gpu_cmd_queue

Command queue and slot sequencer directly upstream of the text-mode GPU, driving its 16-bit `cpuline` command bus. The CPU side pushes (command, parameter) pairs into a FIFO. The block serialises them onto `cpuline` in lock-step with the GPU's fixed sampling pattern: opcode slot, parameter slot, execute slot. It also rejects any opcode the GPU cannot retire, so a bad write never wedges the GPU.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, 2..256.
- `AW`, 4: log2(`DEPTH`).

Ports:
- `clk`  in  1  system clock; the same clock as the GPU command decoder.
- `clr`  in  1  reset, asynchronous, active-low.
- `wr_en`  in  1  push request, one cycle per pair.
- `wr_cmd`  in  16  GPU opcode; legal range 16'h00C0..16'h00C6.
- `wr_param`  in  16  parameter for `wr_cmd`.
- `full`  out  1  FIFO holds `DEPTH` entries.
- `empty`  out  1  FIFO holds 0 entries.
- `count`  out  AW+1  current number of entries.
- `rej`  out  1  one-cycle pulse: the push in the previous cycle was dropped.
- `busy`  out  1  a command is currently occupying GPU slots.
- `cpuline`  out  16  registered command bus to the GPU.

## Operation
- **Slot FSM.** State `S` names the GPU slot served by the current `cpuline` value. States are OP, PAR, EXE.
  - **OP → PAR**
    - Active command: `cpuline` <= latched param.
    - Idle: `cpuline` <= 0.
  - **PAR**
    - Active command: → EXE, `cpuline` <= 0.
    - Idle: → OP, with the launch decision below.
  - **EXE → OP**, with the launch decision below.
- **Launch decision**, taken on every transition into OP:
  - FIFO non-empty: `cpuline` <= head.cmd, latch head.param, pop, set active, `busy` <= 1.
  - FIFO empty: `cpuline` <= 0, clear active, `busy` <= 0.
- Resulting cadence:
  - One command = 3 cycles (op, param, 0).
  - Idle = 2-cycle pairs of 0,0. This matches the GPU's idle loop, where opcode 0 is a NOP pair.
- **Push validation.** A push is stored only if `wr_cmd` is in 16'h00C0..16'h00C6 and `full`=0. Otherwise it is dropped and `rej`=1 on the next cycle.
  - Opcode 0 and all out-of-range opcodes are dropped because the GPU has no default arm and would hang.
- **Push/pop in the same cycle**
  - Not full: both happen and `count` is unchanged.
  - Full: the push is rejected even if a pop occurs in the same cycle.
- **No bypass.** An entry pushed at edge k becomes eligible for launch at edge k+1 or later.
- **Pointers and count.** Read and write pointers are AW bits and wrap modulo `DEPTH`. `count` is AW+1 bits. `full` = (`count`==`DEPTH`); `empty` = (`count`==0).
- **Reset.** Asserting `clr` at any time immediately:
  - flushes the FIFO;
  - sets `S`=OP;
  - sets `cpuline`=0, `busy`=0, `rej`=0, `count`=0, `full`=0, `empty`=1.

  The GPU decoder has no reset, so `clr` is asserted only together with GPU configuration. Slot alignment after a mid-command reset is not guaranteed, and this is a documented system constraint.

## Timing
- **Outputs.** All outputs are registered; `cpuline` is driven straight from a flop.
- **Reset values:** `cpuline`=0, `full`=0, `empty`=1, `count`=0, `rej`=0, `busy`=0. The first cycle after release is an idle OP slot.
- **Launch latency.** Push into an empty queue at edge k: the opcode appears on `cpuline` at edge k+1 or k+2, depending on slot phase.
  - The worst case is k+2, when edge k+1 lands on PAR of an idle pair.
- **Param timing.** Param appears exactly 1 cycle after its opcode, then 0 for exactly 1 cycle.
  - The next opcode can appear on the cycle right after the EXE slot.
- **Throughput.** Sustained maximum is 1 command per 3 cycles. A full queue of `DEPTH` entries drains in 3×`DEPTH` cycles.
- **Status timing.** `count`, `full` and `empty` update on the edge after the push or pop. `rej` is high for exactly one cycle per dropped push.
- **`busy` timing.** `busy` rises on the edge that drives the opcode and falls on the edge that enters an idle OP.

## Test plan
- **Reset idle:** release `clr` with no pushes, run 20 cycles -> `cpuline` 0 every cycle, `S` alternates OP/PAR, `empty`=1, `busy`=0.
- **Single command:** push (16'h00C1, 16'h0041) -> `cpuline` sequence 00C1, 0041, 0000 on consecutive cycles, then idle 0,0 pairs; `busy` high for exactly 3 cycles.
- **Back-to-back:** push C3/0005, C4/0010, C1/0048 in 3 consecutive cycles -> 9 consecutive cycles of C3,5,0,C4,10,0,C1,48,0; `count` peaks at 2 or 3 and returns to 0.
- **Illegal opcodes:** push 0000/1234, 00C7/0001, FFFF/0000 -> `rej` pulses 3 times, `count` stays 0, `cpuline` never shows these values.
- **Full boundary:** push `DEPTH`+1 legal pairs with the GPU saturated -> `full`=1 after `DEPTH`, last push rejected; pushing at full while a pop occurs is also rejected; drain order matches push order, with pointer wrap exercised.
- **Reset mid-command:** assert `clr` during a PAR slot of C1/0041 -> same-cycle `cpuline`=0, `busy`=0, `count`=0; after release the first push launches from OP normally.

Source files
------------

// File: rtl/gpu_cmd_queue.sv
// Command FIFO plus slot sequencer that feeds the text-mode GPU's cpuline bus
// in its fixed opcode / parameter / execute sampling pattern.
module gpu_cmd_queue #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          wr_en,
   input  logic [15:0]   wr_cmd,
   input  logic [15:0]   wr_param,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count,
   output logic          rej,
   output logic          busy,
   output logic [15:0]   cpuline
);

   typedef enum logic [1:0] {
      S_OP  = 2'd0,
      S_PAR = 2'd1,
      S_EXE = 2'd2
   } slot_t;

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   slot_t         r_state, w_state_nxt;
   logic [15:0]   r_mem_cmd [DEPTH];
   logic [15:0]   r_mem_par [DEPTH];
   logic [AW-1:0] r_wptr, r_rptr;
   logic [AW:0]   r_count, w_count_nxt;
   logic          r_full, r_empty, r_rej;
   logic          r_active, w_active_nxt;
   logic [15:0]   r_cpuline, w_cpuline_nxt;
   logic [15:0]   r_param, w_param_nxt;
   logic          w_legal, w_push, w_pop, w_launch;

   // Only opcodes the GPU decoder can retire are queued; anything else would hang it.
   assign w_legal = (wr_cmd >= 16'h00C0) && (wr_cmd <= 16'h00C6);
   assign w_push  = wr_en && w_legal && !r_full;

   always_comb begin
      w_state_nxt   = r_state;
      w_cpuline_nxt = r_cpuline;
      w_active_nxt  = r_active;
      w_param_nxt   = r_param;
      w_launch      = 1'b0;
      w_pop         = 1'b0;
      case (r_state)
         S_OP: begin
            w_state_nxt   = S_PAR;
            w_cpuline_nxt = r_active ? r_param : 16'h0000;
         end
         S_PAR: begin
            if (r_active) begin
               w_state_nxt   = S_EXE;
               w_cpuline_nxt = 16'h0000;
            end else begin
               w_launch = 1'b1;
            end
         end
         default: w_launch = 1'b1;
      endcase
      // Every entry into OP decides between launching the head entry and an idle pair.
      if (w_launch) begin
         w_state_nxt = S_OP;
         if (!r_empty) begin
            w_cpuline_nxt = r_mem_cmd[r_rptr];
            w_param_nxt   = r_mem_par[r_rptr];
            w_pop         = 1'b1;
            w_active_nxt  = 1'b1;
         end else begin
            w_cpuline_nxt = 16'h0000;
            w_active_nxt  = 1'b0;
         end
      end
   end

   assign w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_state   <= S_OP;
         r_cpuline <= 16'h0000;
         r_param   <= 16'h0000;
         r_active  <= 1'b0;
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_count   <= '0;
         r_full    <= 1'b0;
         r_empty   <= 1'b1;
         r_rej     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cpuline <= w_cpuline_nxt;
         r_param   <= w_param_nxt;
         r_active  <= w_active_nxt;
         r_count   <= w_count_nxt;
         r_full    <= (w_count_nxt == FULL_CNT);
         r_empty   <= (w_count_nxt == '0);
         r_rej     <= wr_en && !w_push;
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_cmd[r_wptr] <= wr_cmd;
         r_mem_par[r_wptr] <= wr_param;
      end
   end

   assign full    = r_full;
   assign empty   = r_empty;
   assign count   = r_count;
   assign rej     = r_rej;
   assign busy    = r_active;
   assign cpuline = r_cpuline;

endmodule

// File: tb/tb_gpu_cmd_queue.sv
// Randomized bench for gpu_cmd_queue: the reference views cpuline as a stream of
// 3-word command groups and 2-word idle groups drawn from a queue of accepted pushes.
module tb_gpu_cmd_queue;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          clr = 1'b1;
   logic          wr_en = 1'b0;
   logic [15:0]   wr_cmd = 16'h0000;
   logic [15:0]   wr_param = 16'h0000;
   logic          full, empty, rej, busy;
   logic [AW:0]   count;
   logic [15:0]   cpuline;

   int n_checks = 0;
   int n_errors = 0;

   gpu_cmd_queue #(.DEPTH(DEPTH), .AW(AW)) u_dut (
      .clk(clk), .clr(clr), .wr_en(wr_en), .wr_cmd(wr_cmd), .wr_param(wr_param),
      .full(full), .empty(empty), .count(count), .rej(rej), .busy(busy),
      .cpuline(cpuline)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // reference state
   logic [15:0] mq_cmd [$];
   logic [15:0] mq_par [$];
   logic [15:0] st_word [$];
   logic        st_busy [$];
   logic [15:0] exp_cur;
   logic        exp_busy, exp_rej;
   int          exp_count;

   always @(posedge clk or negedge clr) begin
      if (!clr) begin
         mq_cmd.delete(); mq_par.delete();
         st_word.delete(); st_busy.delete();
         st_word.push_back(16'h0000); st_busy.push_back(1'b0);
         exp_cur = 16'h0000; exp_busy = 1'b0; exp_rej = 1'b0; exp_count = 0;
      end else begin
         int  pre;
         bit  acc;
         pre = mq_cmd.size();
         acc = wr_en && (wr_cmd >= 16'h00C0) && (wr_cmd <= 16'h00C6) && (pre < DEPTH);
         if (st_word.size() == 0) begin
            if (pre > 0) begin
               st_word.push_back(mq_cmd.pop_front());
               st_word.push_back(mq_par.pop_front());
               st_word.push_back(16'h0000);
               repeat (3) st_busy.push_back(1'b1);
            end else begin
               repeat (2) st_word.push_back(16'h0000);
               repeat (2) st_busy.push_back(1'b0);
            end
         end
         exp_cur  = st_word.pop_front();
         exp_busy = st_busy.pop_front();
         if (acc) begin
            mq_cmd.push_back(wr_cmd);
            mq_par.push_back(wr_param);
         end
         exp_rej   = wr_en && !acc;
         exp_count = mq_cmd.size();
      end
   end

   always @(negedge clk) begin
      if (clr) begin
         check_val("cpuline", 32'(cpuline), 32'(exp_cur));
         check_val("busy",    32'(busy),    32'(exp_busy));
         check_val("count",   32'(count),   32'(exp_count));
         check_val("full",    32'(full),    32'(exp_count == DEPTH));
         check_val("empty",   32'(empty),   32'(exp_count == 0));
         check_val("rej",     32'(rej),     32'(exp_rej));
      end
   end

   task automatic drive(input logic e, input logic [15:0] c, input logic [15:0] p);
      wr_en = e; wr_cmd = c; wr_param = p;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 16'h0000, 16'h0000);
   endtask

   function automatic logic [15:0] legal_cmd();
      return 16'h00C0 + 16'($urandom_range(0, 6));
   endfunction

   initial begin
      #1 clr = 1'b0;
      #2;
      check_val("rst_cpuline", 32'(cpuline), 32'h0);
      check_val("rst_busy",    32'(busy),    32'h0);
      check_val("rst_count",   32'(count),   32'h0);
      check_val("rst_empty",   32'(empty),   32'h1);
      check_val("rst_full",    32'(full),    32'h0);
      check_val("rst_rej",     32'(rej),     32'h0);
      @(negedge clk); clr = 1'b1;
      @(posedge clk); #1;

      idle(20);
      drive(1'b1, 16'h00C1, 16'h0041);
      idle(10);
      drive(1'b1, 16'h00C3, 16'h0005);
      drive(1'b1, 16'h00C4, 16'h0010);
      drive(1'b1, 16'h00C1, 16'h0048);
      idle(14);
      drive(1'b1, 16'h0000, 16'h1234);
      drive(1'b1, 16'h00C7, 16'h0001);
      drive(1'b1, 16'hFFFF, 16'h0000);
      idle(4);

      for (int i = 0; i < 40; i++) drive(1'b1, legal_cmd(), 16'($urandom));
      idle(3 * DEPTH + 6);

      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 99) < 60) begin
            if ($urandom_range(0, 9) < 8) drive(1'b1, legal_cmd(), 16'($urandom));
            else                          drive(1'b1, 16'($urandom), 16'($urandom));
         end else begin
            drive(1'b0, 16'($urandom), 16'($urandom));
         end
      end
      idle(3 * DEPTH + 6);

      drive(1'b1, 16'h00C1, 16'h0041);
      for (int i = 0; i < 10 && exp_cur != 16'h0041; i++) idle(1);
      check_val("mid_par", 32'(cpuline), 32'h0041);
      clr = 1'b0;
      #1;
      check_val("mid_rst_cpuline", 32'(cpuline), 32'h0);
      check_val("mid_rst_busy",    32'(busy),    32'h0);
      check_val("mid_rst_count",   32'(count),   32'h0);
      check_val("mid_rst_empty",   32'(empty),   32'h1);
      @(negedge clk); clr = 1'b1;
      @(posedge clk); #1;
      drive(1'b1, 16'h00C5, 16'h0077);
      idle(12);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
